// File: rtl/nn_scale_ctrl.sv
// Nearest-neighbour scaling sequencer: walks a source frame one pixel at a time,
// issuing synchronous source reads and 1x copy, 2x2 replicated or 2x decimated writes.
module nn_scale_ctrl #(
   parameter int WIDTH  = 160,
   parameter int HEIGHT = 120,
   parameter int DW     = 8,
   parameter int SAW    = 15,
   parameter int DAW    = 17
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           start_i,
   input  logic [1:0]     mode_i,
   output logic           busy_o,
   output logic           done_o,
   output logic           err_o,
   output logic           src_rd_o,
   output logic [SAW-1:0] src_addr_o,
   input  logic [DW-1:0]  src_data_i,
   output logic           dst_we_o,
   output logic [DAW-1:0] dst_addr_o,
   output logic [DW-1:0]  dst_data_o,
   input  logic           dst_ready_i
);

   localparam int SXW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int SYW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   localparam logic [1:0] M_COPY = 2'd0;
   localparam logic [1:0] M_ZIN  = 2'd1;
   localparam logic [1:0] M_ZOUT = 2'd2;
   localparam logic [1:0] M_ILL  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_LATCH,
      S_WRITE,
      S_DONE
   } state_e;

   state_e         state_q, state_d;
   logic [1:0]     mode_q, mode_d;
   logic [SXW-1:0] sx_q, sx_d;
   logic [SYW-1:0] sy_q, sy_d;
   logic           rx_q, rx_d;
   logic           ry_q, ry_d;
   logic [DW-1:0]  pix_q, pix_d;
   logic           err_q, err_d;

   logic [SXW-1:0] x_last;
   logic [SYW-1:0] y_last;
   logic [SAW-1:0] src_addr;
   logic [DAW-1:0] dst_addr;

   // Zoom-out walks half the frame; an odd trailing row/column is never visited.
   assign x_last = (mode_q == M_ZOUT) ? SXW'(WIDTH / 2 - 1)  : SXW'(WIDTH - 1);
   assign y_last = (mode_q == M_ZOUT) ? SYW'(HEIGHT / 2 - 1) : SYW'(HEIGHT - 1);

   always_comb begin
      if (mode_q == M_ZOUT)
         src_addr = (SAW'(sy_q) << 1) * SAW'(WIDTH) + (SAW'(sx_q) << 1);
      else
         src_addr = SAW'(sy_q) * SAW'(WIDTH) + SAW'(sx_q);
   end

   always_comb begin
      case (mode_q)
         M_ZIN:   dst_addr = ((DAW'(sy_q) << 1) + DAW'(ry_q)) * DAW'(2 * WIDTH)
                             + (DAW'(sx_q) << 1) + DAW'(rx_q);
         M_ZOUT:  dst_addr = DAW'(sy_q) * DAW'(WIDTH / 2) + DAW'(sx_q);
         default: dst_addr = DAW'(sy_q) * DAW'(WIDTH) + DAW'(sx_q);
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         mode_q  <= M_COPY;
         sx_q    <= '0;
         sy_q    <= '0;
         rx_q    <= 1'b0;
         ry_q    <= 1'b0;
         pix_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         rx_q    <= rx_d;
         ry_q    <= ry_d;
         pix_q   <= pix_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      rx_d    = rx_q;
      ry_d    = ry_q;
      pix_d   = pix_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (mode_i == M_ILL) begin
                  err_d = 1'b1;
               end else begin
                  mode_d  = mode_i;
                  sx_d    = '0;
                  sy_d    = '0;
                  rx_d    = 1'b0;
                  ry_d    = 1'b0;
                  state_d = S_READ;
               end
            end
         end
         S_READ:  state_d = S_LATCH;
         S_LATCH: begin
            pix_d   = src_data_i;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (dst_ready_i) begin
               // Replica order (ry,rx): 00, 01, 10, 11 -- rx is the inner loop.
               if (mode_q == M_ZIN && !(rx_q && ry_q)) begin
                  rx_d = ~rx_q;
                  ry_d = ry_q | rx_q;
               end else begin
                  rx_d = 1'b0;
                  ry_d = 1'b0;
                  if (sx_q == x_last) begin
                     sx_d = '0;
                     if (sy_q == y_last) begin
                        state_d = S_DONE;
                     end else begin
                        sy_d    = sy_q + 1'b1;
                        state_d = S_READ;
                     end
                  end else begin
                     sx_d    = sx_q + 1'b1;
                     state_d = S_READ;
                  end
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Address/data buses are forced to zero outside their strobe so that idle
   // and reset present an all-zero interface.
   assign busy_o     = (state_q != S_IDLE);
   assign done_o     = (state_q == S_DONE);
   assign err_o      = err_q;
   assign src_rd_o   = (state_q == S_READ);
   assign src_addr_o = src_rd_o ? src_addr : '0;
   assign dst_we_o   = (state_q == S_WRITE);
   assign dst_addr_o = dst_we_o ? dst_addr : '0;
   assign dst_data_o = dst_we_o ? pix_q : '0;

endmodule

// File: tb/tb_nn_scale_ctrl.sv
// Bench for nn_scale_ctrl: a 2x2 and a 4x4 instance, checked against a
// frame-level model of copy / zoom-in / zoom-out plus handshake timing.
module tb_nn_scale_ctrl;

   localparam int AW = 2, AH = 2, ASAW = 2, ADAW = 4;
   localparam int BW = 4, BH = 4, BSAW = 4, BDAW = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       dst_ready = 1'b1;
   logic [1:0] mode = 2'd0;
   logic       a_start = 1'b0, b_start = 1'b0;
   logic       sel = 1'b0;

   logic            a_busy, a_done, a_err, a_rd, a_we;
   logic [ASAW-1:0] a_saddr;
   logic [ADAW-1:0] a_daddr;
   logic [7:0]      a_sdata, a_ddata;
   logic            b_busy, b_done, b_err, b_rd, b_we;
   logic [BSAW-1:0] b_saddr;
   logic [BDAW-1:0] b_daddr;
   logic [7:0]      b_sdata, b_ddata;

   logic [7:0] mem_a [AW*AH];
   logic [7:0] mem_b [BW*BH];

   nn_scale_ctrl #(.WIDTH(AW), .HEIGHT(AH), .DW(8), .SAW(ASAW), .DAW(ADAW)) dut_a (
      .clk_i(clk), .rst_i(rst), .start_i(a_start), .mode_i(mode),
      .busy_o(a_busy), .done_o(a_done), .err_o(a_err),
      .src_rd_o(a_rd), .src_addr_o(a_saddr), .src_data_i(a_sdata),
      .dst_we_o(a_we), .dst_addr_o(a_daddr), .dst_data_o(a_ddata), .dst_ready_i(dst_ready));

   nn_scale_ctrl #(.WIDTH(BW), .HEIGHT(BH), .DW(8), .SAW(BSAW), .DAW(BDAW)) dut_b (
      .clk_i(clk), .rst_i(rst), .start_i(b_start), .mode_i(mode),
      .busy_o(b_busy), .done_o(b_done), .err_o(b_err),
      .src_rd_o(b_rd), .src_addr_o(b_saddr), .src_data_i(b_sdata),
      .dst_we_o(b_we), .dst_addr_o(b_daddr), .dst_data_o(b_ddata), .dst_ready_i(dst_ready));

   // Synchronous-read source frames: data valid the cycle after the strobe.
   always @(posedge clk) if (a_rd) a_sdata <= mem_a[a_saddr];
   always @(posedge clk) if (b_rd) b_sdata <= mem_b[b_saddr];

   logic        busy, done, err, rd, we;
   logic [31:0] saddr, daddr;
   logic [7:0]  ddata;
   always_comb begin
      if (sel) begin
         busy = b_busy; done = b_done; err = b_err; rd = b_rd; we = b_we;
         saddr = 32'(b_saddr); daddr = 32'(b_daddr); ddata = b_ddata;
      end else begin
         busy = a_busy; done = a_done; err = a_err; rd = a_rd; we = a_we;
         saddr = 32'(a_saddr); daddr = 32'(a_daddr); ddata = a_ddata;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   int wa[$], wd[$], ra[$];
   int ea[$], ed[$], er[$];
   int exp_base;
   int done_cyc, done_cnt, err_cyc, err_cnt, busy_first, busy_last;
   int viol, stalls, aborted;
   logic post_busy, post_done;

   function automatic int px(input logic s, input int idx);
      return s ? int'(mem_b[idx]) : int'(mem_a[idx]);
   endfunction

   // Expected write/read streams straight from the scaling rules.
   task automatic build_model(input logic s, input logic [1:0] m);
      int w, h;
      w = s ? BW : AW;
      h = s ? BH : AH;
      ea.delete(); ed.delete(); er.delete();
      if (m == 2'd2) begin
         for (int y = 0; y < h / 2; y++)
            for (int x = 0; x < w / 2; x++) begin
               er.push_back(2 * y * w + 2 * x);
               ea.push_back(y * (w / 2) + x);
               ed.push_back(px(s, 2 * y * w + 2 * x));
            end
         exp_base = 3 * (h / 2) * (w / 2) + 1;
      end else begin
         for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
               er.push_back(y * w + x);
               if (m == 2'd0) begin
                  ea.push_back(y * w + x);
                  ed.push_back(px(s, y * w + x));
               end else begin
                  for (int ry = 0; ry < 2; ry++)
                     for (int rx = 0; rx < 2; rx++) begin
                        ea.push_back((2 * y + ry) * (2 * w) + 2 * x + rx);
                        ed.push_back(px(s, y * w + x));
                     end
               end
            end
         exp_base = (m == 2'd0 ? 3 : 6) * h * w + 1;
      end
   endtask

   function automatic int wr_diff();
      if (wa.size() != ea.size()) return -2;
      foreach (ea[i]) if (wa[i] != ea[i] || wd[i] != ed[i]) return i;
      return -1;
   endfunction

   function automatic int rd_diff();
      if (ra.size() != er.size()) return -2;
      foreach (er[i]) if (ra[i] != er[i]) return i;
      return -1;
   endfunction

   // policy: 0 ready high, 1 stall 3 cycles on every 2nd write, 2 random ready.
   // pulse_at: cycle to pulse a (to be ignored) zoom-in start; abort_w: reset
   // while write number abort_w (0-based) is pending.
   task automatic run_cmd(input logic s, input logic [1:0] m, input int policy,
                          input int pulse_at, input int abort_w, input int max_cyc);
      int this_stall, prev_stall, p_addr, p_data;
      sel = s;
      wa.delete(); wd.delete(); ra.delete();
      done_cyc = -1; done_cnt = 0; err_cyc = -1; err_cnt = 0;
      busy_first = -1; busy_last = -1; viol = 0; stalls = 0; aborted = 0;
      post_busy = 1'bx; post_done = 1'bx;
      this_stall = 0; prev_stall = 0; p_addr = 0; p_data = 0;
      @(posedge clk); #1;
      mode = m;
      if (s) b_start = 1'b1; else a_start = 1'b1;
      @(posedge clk);
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         #1;
         a_start = 1'b0; b_start = 1'b0;
         if (cyc == pulse_at) begin
            mode = 2'd1;
            if (s) b_start = 1'b1; else a_start = 1'b1;
         end
         if (policy == 0)      dst_ready = 1'b1;
         else if (policy == 1) dst_ready = !(we && (wa.size() % 2 == 1) && this_stall < 3);
         else                  dst_ready = ($urandom_range(0, 2) != 0);
         if (we && !dst_ready) begin stalls++; this_stall++; end
         @(negedge clk);
         if (rd && we) viol++;
         if (prev_stall != 0 && !(we && int'(daddr) == p_addr && int'(ddata) == p_data)) viol++;
         prev_stall = (we && !dst_ready) ? 1 : 0;
         p_addr = int'(daddr); p_data = int'(ddata);
         if (rd) ra.push_back(int'(saddr));
         if (busy) begin if (busy_first < 0) busy_first = cyc; busy_last = cyc; end
         if (err) begin err_cnt++; if (err_cyc < 0) err_cyc = cyc; end
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            post_busy = busy; post_done = done;
            break;
         end
         if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
         if (we && abort_w >= 0 && wa.size() == abort_w) begin
            rst = 1'b1; aborted = 1;
            break;
         end
         if (we && dst_ready) begin
            wa.push_back(int'(daddr)); wd.push_back(int'(ddata)); this_stall = 0;
         end
         @(posedge clk);
      end
      dst_ready = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({a_busy, a_done, a_err, a_rd, a_we, a_saddr, a_daddr, a_ddata} !== '0) begin
         n_fail++; $display("FAIL reset_a: outputs %b, expected all zero",
            {a_busy, a_done, a_err, a_rd, a_we, a_saddr, a_daddr, a_ddata});
      end
      n_checks++;
      if ({b_busy, b_done, b_err, b_rd, b_we, b_saddr, b_daddr, b_ddata} !== '0) begin
         n_fail++; $display("FAIL reset_b: outputs %b, expected all zero",
            {b_busy, b_done, b_err, b_rd, b_we, b_saddr, b_daddr, b_ddata});
      end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_copy();
      int xa[4] = '{0, 1, 2, 3};
      int xd[4] = '{2, 4, 7, 9};
      int bad;
      mem_a[0] = 8'd2; mem_a[1] = 8'd4; mem_a[2] = 8'd7; mem_a[3] = 8'd9;
      run_cmd(1'b0, 2'd0, 0, -1, -1, 100);
      build_model(1'b0, 2'd0);
      bad = (wa.size() != 4) ? 1 : 0;
      if (bad == 0) foreach (xa[i]) if (wa[i] != xa[i] || wd[i] != xd[i]) bad = 1;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL copy_pairs: %0d writes, first (%0d,%0d), expected (0,2)..(3,9)", wa.size(), wa.size() ? wa[0] : -1, wd.size() ? wd[0] : -1); end
      n_checks++;
      if (done_cyc != 13) begin n_fail++; $display("FAIL copy_done: cycle %0d, expected 13", done_cyc); end
      n_checks++;
      if (busy_first != 1 || busy_last != 13) begin n_fail++; $display("FAIL copy_busy: cycles %0d-%0d, expected 1-13", busy_first, busy_last); end
      n_checks++;
      if (done_cnt != 1 || post_done !== 1'b0 || post_busy !== 1'b0) begin n_fail++; $display("FAIL copy_pulse: done_cnt %0d post done %b busy %b, expected 1 0 0", done_cnt, post_done, post_busy); end
   endtask

   task automatic test_zoom_in();
      int fexp[16] = '{2, 2, 4, 4, 2, 2, 4, 4, 7, 7, 9, 9, 7, 7, 9, 9};
      int frame[16];
      int bad, d;
      foreach (frame[i]) frame[i] = -1;
      run_cmd(1'b0, 2'd1, 0, -1, -1, 100);
      build_model(1'b0, 2'd1);
      foreach (wa[i]) if (wa[i] >= 0 && wa[i] < 16) frame[wa[i]] = wd[i];
      bad = (wa.size() != 16) ? 1 : 0;
      foreach (fexp[i]) if (frame[i] != fexp[i]) bad = 1;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL zin_frame: %0d writes, row0 %0d %0d %0d %0d, expected 2 2 4 4", wa.size(), frame[0], frame[1], frame[2], frame[3]); end
      d = wr_diff();
      n_checks++;
      if (d != -1) begin n_fail++; $display("FAIL zin_order: diff at %0d (size %0d), expected size %0d", d, wa.size(), ea.size()); end
      d = rd_diff();
      n_checks++;
      if (d != -1) begin n_fail++; $display("FAIL zin_reads: diff at %0d (size %0d), expected size %0d", d, ra.size(), er.size()); end
      n_checks++;
      if (done_cyc != 25) begin n_fail++; $display("FAIL zin_done: cycle %0d, expected 25", done_cyc); end
   endtask

   task automatic test_zoom_out();
      int xr[4] = '{0, 2, 8, 10};
      int bad, d;
      foreach (mem_b[i]) mem_b[i] = 8'(i);
      run_cmd(1'b1, 2'd2, 0, -1, -1, 100);
      build_model(1'b1, 2'd2);
      bad = (ra.size() != 4 || wa.size() != 4) ? 1 : 0;
      if (bad == 0) foreach (xr[i]) if (ra[i] != xr[i] || wa[i] != i || wd[i] != xr[i]) bad = 1;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL zout_literal: %0d reads %0d writes, first read %0d, expected reads 0,2,8,10", ra.size(), wa.size(), ra.size() ? ra[0] : -1); end
      d = wr_diff();
      n_checks++;
      if (d != -1) begin n_fail++; $display("FAIL zout_model: diff at %0d (size %0d), expected size %0d", d, wa.size(), ea.size()); end
      n_checks++;
      if (done_cyc != 13) begin n_fail++; $display("FAIL zout_done: cycle %0d, expected 13", done_cyc); end
   endtask

   task automatic test_stall();
      int d;
      foreach (mem_a[i]) mem_a[i] = 8'($urandom);
      run_cmd(1'b0, 2'd1, 1, -1, -1, 200);
      build_model(1'b0, 2'd1);
      d = wr_diff();
      n_checks++;
      if (d != -1) begin n_fail++; $display("FAIL stall_writes: diff at %0d (size %0d), expected size %0d", d, wa.size(), ea.size()); end
      n_checks++;
      if (stalls != 24) begin n_fail++; $display("FAIL stall_count: %0d stall cycles, expected 24", stalls); end
      n_checks++;
      if (done_cyc != exp_base + stalls) begin n_fail++; $display("FAIL stall_done: cycle %0d, expected %0d", done_cyc, exp_base + stalls); end
      n_checks++;
      if (viol != 0) begin n_fail++; $display("FAIL stall_stable: %0d hold/exclusion violations, expected 0", viol); end
   endtask

   task automatic test_illegal();
      run_cmd(1'b0, 2'd3, 0, -1, -1, 4);
      n_checks++;
      if (err_cnt != 1 || err_cyc != 1) begin n_fail++; $display("FAIL ill_err: %0d pulses first at %0d, expected 1 at 1", err_cnt, err_cyc); end
      n_checks++;
      if (busy_first != -1 || ra.size() != 0 || wa.size() != 0 || done_cyc != -1) begin n_fail++; $display("FAIL ill_quiet: busy at %0d, %0d reads, %0d writes, done %0d, expected none", busy_first, ra.size(), wa.size(), done_cyc); end
   endtask

   task automatic test_start_ignored();
      int d;
      foreach (mem_a[i]) mem_a[i] = 8'($urandom);
      run_cmd(1'b0, 2'd0, 0, 5, -1, 100);
      build_model(1'b0, 2'd0);
      d = wr_diff();
      n_checks++;
      if (d != -1) begin n_fail++; $display("FAIL busy_start_writes: diff at %0d (size %0d), expected size %0d", d, wa.size(), ea.size()); end
      n_checks++;
      if (done_cyc != 13 || done_cnt != 1 || err_cnt != 0) begin n_fail++; $display("FAIL busy_start_done: done %0d x%0d err %0d, expected 13 x1 0", done_cyc, done_cnt, err_cnt); end
   endtask

   task automatic test_reset_mid();
      int d;
      foreach (mem_a[i]) mem_a[i] = 8'($urandom);
      run_cmd(1'b0, 2'd1, 0, -1, 6, 100);
      #1;
      n_checks++;
      if (aborted != 1 || {a_busy, a_done, a_err, a_rd, a_we, a_saddr, a_daddr, a_ddata} !== '0) begin
         n_fail++; $display("FAIL abort_outputs: aborted %0d outputs %b, expected 1 and all zero", aborted,
            {a_busy, a_done, a_err, a_rd, a_we, a_saddr, a_daddr, a_ddata});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (a_done !== 1'b0 || a_busy !== 1'b0 || wa.size() != 6 || done_cnt != 0) begin n_fail++; $display("FAIL abort_state: done %b busy %b writes %0d, expected 0 0 6", a_done, a_busy, wa.size()); end
      @(posedge clk); #1 rst = 1'b0;
      run_cmd(1'b0, 2'd0, 0, -1, -1, 100);
      build_model(1'b0, 2'd0);
      d = wr_diff();
      n_checks++;
      if (d != -1 || done_cyc != 13) begin n_fail++; $display("FAIL abort_restart: diff %0d done %0d, expected -1 and 13", d, done_cyc); end
   endtask

   task automatic test_random();
      int d;
      logic s;
      logic [1:0] m;
      for (int it = 0; it < 8; it++) begin
         s = 1'($urandom_range(0, 1));
         m = 2'($urandom_range(0, 2));
         foreach (mem_a[i]) mem_a[i] = 8'($urandom);
         foreach (mem_b[i]) mem_b[i] = 8'($urandom);
         run_cmd(s, m, 2, -1, -1, 800);
         build_model(s, m);
         d = wr_diff();
         n_checks++;
         if (d != -1) begin n_fail++; $display("FAIL rand%0d_writes: sel %0d mode %0d diff at %0d (size %0d), expected size %0d", it, s, m, d, wa.size(), ea.size()); end
         d = rd_diff();
         n_checks++;
         if (d != -1) begin n_fail++; $display("FAIL rand%0d_reads: sel %0d mode %0d diff at %0d", it, s, m, d); end
         n_checks++;
         if (done_cyc != exp_base + stalls || done_cnt != 1) begin n_fail++; $display("FAIL rand%0d_done: cycle %0d, expected %0d", it, done_cyc, exp_base + stalls); end
         n_checks++;
         if (viol != 0 || post_busy !== 1'b0) begin n_fail++; $display("FAIL rand%0d_proto: violations %0d post busy %b, expected 0 0", it, viol, post_busy); end
      end
   endtask

   initial begin
      test_reset();
      test_copy();
      test_zoom_in();
      test_zoom_out();
      test_stall();
      test_illegal();
      test_start_ignored();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
